// File: rtl/clock_divider_prog.sv
// Programmable clock divider: free-running or single-step output periods of D
// input cycles, with a divisor that changes only on period boundaries.
module clock_divider_prog #(
  parameter int unsigned           WIDTH       = 28,
  parameter logic [WIDTH-1:0]      DEFAULT_DIV = 28'd50000000
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             step_req,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             clock_out,
  output logic             tick,
  output logic             busy,
  output logic             div_err,
  output logic [WIDTH-1:0] div_active
);

  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             at_last;
  logic             apply;
  logic             load_ok;
  logic             busy_d;

  assign at_last = (cnt_q == (div_q - WIDTH'(1)));
  assign load_ok = enable && div_load && (div_value >= WIDTH'(2));
  // A pending divisor takes effect only between periods: while idle or on the last count.
  assign apply   = enable && pend_vld_q && ((state_q == IDLE) || at_last);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= DEFAULT_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = apply ? pend_q : div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q && !apply;
    if (load_ok) begin
      pend_d     = div_value;
      pend_vld_d = 1'b1;
    end
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!mode) begin
            state_d = RUN;
          end else if (step_req) begin
            state_d = STEP;
          end
        end
        RUN: begin
          if (at_last) begin
            cnt_d = '0;
            if (mode) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        STEP: begin
          if (at_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Registered outputs are computed from next-state values so they line up with the counter.
  always_comb begin
    busy_d = (state_d != IDLE);
    clk_d  = clk_q;
    tick_d = 1'b0;
    err_d  = enable && div_load && (div_value < WIDTH'(2));
    if (enable) begin
      clk_d  = busy_d && (cnt_d < (div_d >> 1));
      tick_d = busy_d && (cnt_d == '0);
    end
  end

  assign clock_out  = clk_q;
  assign tick       = tick_q;
  assign busy       = (state_q != IDLE);
  assign div_err    = err_q;
  assign div_active = div_q;

endmodule

// File: doc/clock_divider_prog.md
CLOCK_DIVIDER_PROG -- requirements
Module: clock_divider_prog

Interface
REQ-001 The module SHALL have parameter WIDTH, default 28, the divisor and counter width in bits.
REQ-002 The module SHALL have parameter DEFAULT_DIV, default 28'd50000000, the divisor in force after reset (1 Hz from 50 MHz).
REQ-003 The module SHALL have port clock_in  input  1  the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port enable  input  1  when 1, the counter advances; when 0, all state freezes.
REQ-006 The module SHALL have port mode  input  1  0 selects free-run; 1 selects single-step.
REQ-007 The module SHALL have port step_req  input  1  single-cycle pulse requesting one output period in step mode.
REQ-008 The module SHALL have port div_load  input  1  single-cycle strobe to load div_value.
REQ-009 The module SHALL have port div_value  input  WIDTH  new divisor, in input-clock cycles per output period.
REQ-010 The module SHALL have port clock_out  output  1  divided clock, registered.
REQ-011 The module SHALL have port tick  output  1  one-cycle pulse marking the first cycle of each output period.
REQ-012 The module SHALL have port busy  output  1  high while a period is in progress (states RUN or STEP).
REQ-013 The module SHALL have port div_err  output  1  one-cycle pulse when a loaded div_value is below 2.
REQ-014 The module SHALL have port div_active  output  WIDTH  divisor currently in force (D).

Function
REQ-015 Each period SHALL last D input cycles: counter 0..D-1, with clock_out high for counter values 0..(D>>1)-1 and low otherwise (odd D: high floor(D/2) cycles, low ceil(D/2) cycles).
REQ-016 clock_out and tick SHALL be registered and aligned to the counter value of the same cycle; tick SHALL be 1 only when counter==0 inside a period.
REQ-017 The state machine SHALL have exactly three states: IDLE (counter 0, clock_out 0, tick 0), RUN and STEP.
REQ-018 In IDLE with enable=1: mode=0 SHALL transition to RUN, and mode=1 with step_req=1 SHALL transition to STEP; the first period cycle (counter 0, tick 1) SHALL occur in the cycle after the transition.
REQ-019 RUN SHALL wrap counter D-1 -> 0 continuously; if mode=1 at the D-1 cycle, it SHALL go to IDLE instead of wrapping, so the current period always completes.
REQ-020 STEP SHALL run exactly one period and then return to IDLE at the D-1 cycle; step_req during STEP or RUN SHALL be ignored, not queued.
REQ-021 With enable=0, the counter, state, clock_out and pending registers SHALL hold, tick SHALL be 0, and step_req SHALL be ignored.
REQ-022 div_load with div_value>=2 SHALL store a pending divisor; it SHALL apply at the next period boundary (the D-1 -> 0 transition or entry to IDLE), or on the next cycle if already in IDLE.
REQ-023 A second div_load before the pending divisor applies SHALL overwrite the pending value.
REQ-024 A new divisor SHALL never truncate or stretch the period in progress.
REQ-025 div_load with div_value<2 SHALL leave the divisor and pending value unchanged and SHALL pulse div_err for one cycle.
REQ-026 div_active SHALL change only when a pending divisor applies.
REQ-027 Counter comparisons SHALL use WIDTH-bit unsigned arithmetic, and the counter SHALL never exceed D-1.

Reset
REQ-028 While reset_n=0 (asynchronous), the outputs SHALL be: state IDLE, counter 0, clock_out 0, tick 0, busy 0, div_err 0, div_active DEFAULT_DIV, no pending divisor.
REQ-029 Reset asserted mid-period SHALL abort the period immediately; after reset release, behaviour SHALL follow REQ-018.

Verification
REQ-030 Reset, then D=4 loaded, mode=0, enable=1 -> clock_out 1,1,0,0 repeating; tick 1,0,0,0; busy 1.
REQ-031 D=5, free-run -> clock_out high 2 cycles and low 3 cycles per period; one tick per 5 cycles.
REQ-032 Running D=4, div_load 6 at counter=1 -> the current period finishes at 4 cycles; the next period is 6 cycles; div_active changes at the boundary.
REQ-033 mode=1 in IDLE with D=4, step_req pulse -> exactly one period (1,1,0,0), then IDLE with busy 0; a second step_req mid-period produces no extra period.
REQ-034 div_load 1 -> div_err pulses once, and div_active and the period are unchanged.
REQ-035 enable=0 for 3 cycles at counter=2 -> outputs hold, and the period resumes at counter=2; reset_n low mid-period -> all outputs reach reset values without waiting for a clock edge.
